vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Produces the raster timing that drives the pixel generator and the DAC. It owns the horizontal and vertical pixel counters, which it feeds as hcount/vcount to the screen generator. It also produces HS/VS, the blank/sync strobes and frame and vblank event pulses. Sync and blank are pipelined to stay aligned with the synchronous-ROM latency of the pixel path.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
FRAME_CNT_W, 8, width of frame_count

Ports:
vga_clk  in  1  pixel clock (25 MHz nominal); single clock domain
reset  in  1  synchronous reset, active-high
pixel_en  in  1  pixel advance enable; low = all state holds
hcount  out  10  horizontal counter, 0..H_TOTAL-1 (stage P0)
vcount  out  10  vertical counter, 0..V_TOTAL-1 (stage P0)
vga_hs  out  1  horizontal sync, active-low (pipelined)
vga_vs  out  1  vertical sync, active-low (pipelined)
vga_blank_n  out  1  high during the visible area (pipelined)
vga_sync_n  out  1  DAC composite sync, tied to 0 (registered constant)
video_active  out  1  combinational visible decode of P0 counters, for pixel-path gating
frame_start  out  1  one-cycle pulse, pipelined with syncs
vblank_start  out  1  one-cycle pulse, pipelined with syncs
frame_count  out  FRAME_CNT_W  frames completed, wraps

Behaviour:
- Derived values: H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).
- Reset, held for any number of cycles and overriding pixel_en, drives:
  - hcount = 0, vcount = 0
  - vga_hs = 1, vga_vs = 1, vga_blank_n = 0, vga_sync_n = 0
  - frame_start = 0, vblank_start = 0, frame_count = 0
  - all pipeline registers cleared to these same values
- Reset mid-frame discards the current position. The first post-reset cycle with pixel_en=1 presents (0,0) at P0 and moves to (1,0) on the next edge.
- Stage P0, counters:
  - On each edge with pixel_en=1, hcount increments.
  - At hcount = H_TOTAL-1, hcount wraps to 0 and vcount increments.
  - At (H_TOTAL-1, V_TOTAL-1), both counters wrap to 0 and frame_count increments, modulo 2^FRAME_CNT_W (255 -> 0).
  - With pixel_en=0, nothing changes, including pulses, which hold their value.
- Stage P1, registered decode of the P0 counters, updated only when pixel_en=1:
  - hs_d = 0 iff H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vs_d = 0 iff V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491.
  - blank_n_d = 1 iff hcount < H_VISIBLE and vcount < V_VISIBLE.
  - frame_start_d = 1 iff (hcount,vcount) = (0,0).
  - vblank_start_d = 1 iff (hcount,vcount) = (0,V_VISIBLE).
- Output latency:
  - vga_hs, vga_vs, vga_blank_n, frame_start and vblank_start are the P1 registers.
  - They therefore lag hcount/vcount by exactly one enabled cycle, matching the one-cycle synchronous ROM read in the pixel path.
- video_active is the only combinational output. It is a zero-latency decode, with the same definition as blank_n_d.
- Each pulse is high for exactly one enabled cycle per frame.
- vblank_start marks the safe window for game logic to update board state.
- Each hsync is 96 enabled cycles wide, and the period between hsync falling edges is 800. Each vsync is 2 lines (1600 cycles) wide.
- No counter state outside 0..TOTAL-1 is reachable. If one is reached anyway (e.g. after an SEU), the counter wraps to 0 on the next enabled edge.

Optional Feature:
- Macro: VGA_SYNC_PIPE2_EN.
- Defined:
  - A second register stage P2 is inserted after P1 for hs, vs, blank_n, frame_start and vblank_start.
  - Output latency becomes 2 enabled cycles, for ROMs with registered outputs.
  - P2 is reset to the same values as P1 and gated by pixel_en.
- Undefined: outputs come from P1 (latency 1). The P0 counters and video_active are unaffected in both cases.

Test Plan:
- Reset: assert reset for 3 cycles with pixel_en=1 -> hcount=0, vcount=0, vga_hs=1, vga_vs=1, vga_blank_n=0, frame_count=0. The first enabled edge after release gives hcount=1.
- Line timing: run 2 lines -> vga_hs falls one cycle after hcount=656, rises one cycle after hcount=752. vga_blank_n falls one cycle after hcount=640. vcount increments after hcount=799.
- Frame timing: run 2 full frames (2×420000 cycles) -> vga_vs low for 1600 cycles, starting one cycle after (0,490). frame_start is seen twice, 420000 cycles apart. vblank_start fires one cycle after (0,480). frame_count = 2.
- Enable hold: pixel_en toggled 1,0,0,1 at hcount=100 -> hcount goes 101, 101, 101, 102. vga_hs, vga_blank_n and the pulses are unchanged during the hold.
- Reset mid-frame: reset at (hcount=700, vcount=300) -> next cycle all outputs at reset values and no extra frame_count increment. Force frame_count=255, then complete a frame -> 0.
- Macro: with VGA_SYNC_PIPE2_EN defined -> vga_hs falls 2 cycles after hcount=656. Undefined -> 1 cycle.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, pipelined sync/blank strobes, frame events.
// Define VGA_SYNC_PIPE2_EN for a second strobe stage (output latency 2).
module vga_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  input  logic                   pixel_en,
  output logic [9:0]             hcount,
  output logic [9:0]             vcount,
  output logic                   vga_hs,
  output logic                   vga_vs,
  output logic                   vga_blank_n,
  output logic                   vga_sync_n,
  output logic                   video_active,
  output logic                   frame_start,
  output logic                   vblank_start,
  output logic [FRAME_CNT_W-1:0] frame_count
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
    logic frame_start;
    logic vblank_start;
  } strobe_t;

  localparam strobe_t STROBE_RST = '{
    hs: 1'b1, vs: 1'b1, blank_n: 1'b0,
    frame_start: 1'b0, vblank_start: 1'b0
  };

  strobe_t dec;
  strobe_t p1;
  strobe_t q;
  logic    h_wrap;
  logic    sync_n_q;

  // >= catches out-of-range states so they fall back to 0
  assign h_wrap = (hcount >= H_LAST);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      frame_count <= '0;
    end else if (pixel_en) begin
      hcount <= h_wrap ? 10'd0 : hcount + 10'd1;
      if (vcount > V_LAST) begin
        vcount <= '0;
      end else if (h_wrap) begin
        if (vcount == V_LAST) begin
          vcount      <= '0;
          frame_count <= frame_count + FRAME_CNT_W'(1);
        end else begin
          vcount <= vcount + 10'd1;
        end
      end
    end
  end

  assign video_active = (hcount < H_VIS) && (vcount < V_VIS);

  always_comb begin
    dec              = STROBE_RST;
    dec.hs           = !((hcount >= HS_BEG) && (hcount < HS_END));
    dec.vs           = !((vcount >= VS_BEG) && (vcount < VS_END));
    dec.blank_n      = video_active;
    dec.frame_start  = (hcount == 10'd0) && (vcount == 10'd0);
    dec.vblank_start = (hcount == 10'd0) && (vcount == V_VIS);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      p1 <= STROBE_RST;
    end else if (pixel_en) begin
      p1 <= dec;
    end
  end

`ifdef VGA_SYNC_PIPE2_EN
  strobe_t p2;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      p2 <= STROBE_RST;
    end else if (pixel_en) begin
      p2 <= p1;
    end
  end

  assign q = p2;
`else
  assign q = p1;
`endif

  // composite sync is unused by the DAC; keep it a clean registered 0
  always_ff @(posedge vga_clk) begin
    sync_n_q <= 1'b0;
  end

  assign vga_hs       = q.hs;
  assign vga_vs       = q.vs;
  assign vga_blank_n  = q.blank_n;
  assign frame_start  = q.frame_start;
  assign vblank_start = q.vblank_start;
  assign vga_sync_n   = sync_n_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench, full-size DUT for line timing and a
// shrunken-raster DUT for frame-level timing within a short run.
module tb_vga_timing_gen;
`ifdef VGA_SYNC_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
    logic fs;
    logic vbs;
  } dec_t;

  localparam dec_t RST_DEC = 5'b11000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pixel_en = 1'b0;

  logic [9:0] b_h, b_v, s_h, s_v;
  logic       b_hs, b_vs, b_bn, b_sn, b_va, b_fs, b_vbs;
  logic       s_hs, s_vs, s_bn, s_sn, s_va, s_fs, s_vbs;
  logic [7:0] b_fc, s_fc;

  int vectors = 0;
  int errors  = 0;

  int   bh = 0, bv = 0, bfc = 0;
  int   sh = 0, sv = 0, sfc = 0;
  dec_t bq[$];
  dec_t sq[$];
  dec_t bexp = RST_DEC;
  dec_t sexp = RST_DEC;

  always #5 clk = ~clk;

  vga_timing_gen u_big (
    .vga_clk(clk), .reset(reset), .pixel_en(pixel_en),
    .hcount(b_h), .vcount(b_v),
    .vga_hs(b_hs), .vga_vs(b_vs),
    .vga_blank_n(b_bn), .vga_sync_n(b_sn),
    .video_active(b_va),
    .frame_start(b_fs), .vblank_start(b_vbs),
    .frame_count(b_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .FRAME_CNT_W(8)
  ) u_small (
    .vga_clk(clk), .reset(reset), .pixel_en(pixel_en),
    .hcount(s_h), .vcount(s_v),
    .vga_hs(s_hs), .vga_vs(s_vs),
    .vga_blank_n(s_bn), .vga_sync_n(s_sn),
    .video_active(s_va),
    .frame_start(s_fs), .vblank_start(s_vbs),
    .frame_count(s_fc)
  );

  function automatic dec_t decode(
    input int h, input int v,
    input int hv, input int hf, input int hsw,
    input int vv, input int vf, input int vsw
  );
    dec_t d;
    d.hs      = !(h >= hv + hf && h < hv + hf + hsw);
    d.vs      = !(v >= vv + vf && v < vv + vf + vsw);
    d.blank_n = (h < hv) && (v < vv);
    d.fs      = (h == 0) && (v == 0);
    d.vbs     = (h == 0) && (v == vv);
    return d;
  endfunction

  function automatic logic [34:0] exp_vec(
    input int h, input int v, input dec_t d,
    input int fc, input int hv, input int vv
  );
    logic va;
    va = (h < hv) && (v < vv);
    return {10'(h), 10'(v), d, va, 1'b0, 8'(fc)};
  endfunction

  function automatic logic [34:0] b_exp();
    return exp_vec(bh, bv, bexp, bfc, 640, 480);
  endfunction

  function automatic logic [34:0] s_exp();
    return exp_vec(sh, sv, sexp, sfc, 8, 6);
  endfunction

  function automatic logic [34:0] b_got();
    return {b_h, b_v, b_hs, b_vs, b_bn, b_fs, b_vbs, b_va, b_sn, b_fc};
  endfunction

  function automatic logic [34:0] s_got();
    return {s_h, s_v, s_hs, s_vs, s_bn, s_fs, s_vbs, s_va, s_sn, s_fc};
  endfunction

  // one clock: drive inputs, push the pre-edge decode, advance the model
  task automatic tick(input logic rst, input logic en);
    dec_t bd, sd;
    reset    = rst;
    pixel_en = en;
    bd = decode(bh, bv, 640, 16, 96, 480, 10, 2);
    sd = decode(sh, sv, 8, 2, 3, 6, 1, 2);
    @(posedge clk);
    #1;
    if (rst) begin
      bh = 0; bv = 0; bfc = 0;
      sh = 0; sv = 0; sfc = 0;
      bq.delete();
      sq.delete();
      for (int i = 0; i < LAT - 1; i++) begin
        bq.push_back(RST_DEC);
        sq.push_back(RST_DEC);
      end
      bexp = RST_DEC;
      sexp = RST_DEC;
    end else if (en) begin
      bq.push_back(bd);
      bexp = bq.pop_front();
      sq.push_back(sd);
      sexp = sq.pop_front();
      if (bh == 799) begin
        bh = 0;
        if (bv == 524) begin
          bv = 0;
          bfc = (bfc + 1) % 256;
        end else bv++;
      end else bh++;
      if (sh == 15) begin
        sh = 0;
        if (sv == 9) begin
          sv = 0;
          sfc = (sfc + 1) % 256;
        end else sv++;
      end else sh++;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
    vectors++;
    if ({b_h, b_v, b_hs, b_vs, b_bn, b_sn, b_fs, b_vbs, b_fc} !==
        {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_big got %h", b_got());
    end
    vectors++;
    if ({s_h, s_v, s_hs, s_vs, s_bn, s_sn, s_fs, s_vbs, s_fc} !==
        {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_small got %h", s_got());
    end
    tick(1'b0, 1'b1);
    vectors++;
    if (b_h !== 10'd1 || b_v !== 10'd0) begin
      errors++;
      $display("FAIL reset_first_edge got %0d,%0d exp 1,0", b_h, b_v);
    end
    vectors++;
    if (b_got() !== b_exp()) begin
      errors++;
      $display("FAIL reset_sb got %h exp %h", b_got(), b_exp());
    end
  endtask

  task automatic test_line();
    int   hs_fall, hs_rise, bn_fall;
    logic ph, pb;
    hs_fall = -1; hs_rise = -1; bn_fall = -1;
    tick(1'b1, 1'b1);
    ph = b_hs;
    pb = b_bn;
    for (int i = 0; i < 1600; i++) begin
      tick(1'b0, 1'b1);
      vectors++;
      if (b_got() !== b_exp()) begin
        errors++;
        $display("FAIL line_sb cyc %0d got %h exp %h", i, b_got(), b_exp());
      end
      if (ph && !b_hs && hs_fall < 0) hs_fall = int'(b_h);
      if (!ph && b_hs && hs_rise < 0) hs_rise = int'(b_h);
      if (pb && !b_bn && bn_fall < 0) bn_fall = int'(b_h);
      ph = b_hs;
      pb = b_bn;
      if (i == 799) begin
        vectors++;
        if ({b_h, b_v} !== {10'd0, 10'd1}) begin
          errors++;
          $display("FAIL line_vinc got %0d,%0d exp 0,1", b_h, b_v);
        end
      end
    end
    vectors++;
    if (hs_fall != 656 + LAT) begin
      errors++;
      $display("FAIL hs_fall got %0d exp %0d", hs_fall, 656 + LAT);
    end
    vectors++;
    if (hs_rise != 752 + LAT) begin
      errors++;
      $display("FAIL hs_rise got %0d exp %0d", hs_rise, 752 + LAT);
    end
    vectors++;
    if (bn_fall != 640 + LAT) begin
      errors++;
      $display("FAIL blank_fall got %0d exp %0d", bn_fall, 640 + LAT);
    end
  endtask

  task automatic test_enable_hold();
    logic [4:0] held;
    tick(1'b1, 1'b1);
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b1);
    vectors++;
    if (b_h !== 10'd100) begin
      errors++;
      $display("FAIL hold_start got %0d exp 100", b_h);
    end
    tick(1'b0, 1'b1);
    held = {b_hs, b_vs, b_bn, b_fs, b_vbs};
    vectors++;
    if (b_h !== 10'd101) begin
      errors++;
      $display("FAIL hold_en1 got %0d exp 101", b_h);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1'b0, 1'b0);
      vectors++;
      if (b_h !== 10'd101 || {b_hs, b_vs, b_bn, b_fs, b_vbs} !== held) begin
        errors++;
        $display("FAIL hold_en0 got %0d/%b exp 101/%b", b_h,
                 {b_hs, b_vs, b_bn, b_fs, b_vbs}, held);
      end
    end
    tick(1'b0, 1'b1);
    vectors++;
    if (b_h !== 10'd102) begin
      errors++;
      $display("FAIL hold_resume got %0d exp 102", b_h);
    end
    vectors++;
    if (b_got() !== b_exp() || s_got() !== s_exp()) begin
      errors++;
      $display("FAIL hold_sb got %h/%h exp %h/%h",
               b_got(), s_got(), b_exp(), s_exp());
    end
  endtask

  task automatic test_frame();
    int   fs_n, vs_low, vf_h, vf_v, vb_h, vb_v;
    int   fs_t[2];
    logic pvs;
    fs_n = 0; vs_low = 0; vf_h = -1; vf_v = -1; vb_h = -1; vb_v = -1;
    fs_t[0] = -1; fs_t[1] = -1;
    tick(1'b1, 1'b1);
    pvs = s_vs;
    for (int i = 1; i <= 320; i++) begin
      tick(1'b0, 1'b1);
      vectors++;
      if (s_got() !== s_exp()) begin
        errors++;
        $display("FAIL frame_sb cyc %0d got %h exp %h", i, s_got(), s_exp());
      end
      if (s_fs) begin
        if (fs_n < 2) fs_t[fs_n] = i;
        fs_n++;
      end
      if (!s_vs) vs_low++;
      if (pvs && !s_vs && vf_h < 0) begin
        vf_h = int'(s_h);
        vf_v = int'(s_v);
      end
      if (s_vbs && vb_h < 0) begin
        vb_h = int'(s_h);
        vb_v = int'(s_v);
      end
      pvs = s_vs;
    end
    vectors++;
    if (fs_n != 2 || fs_t[0] != LAT || fs_t[1] - fs_t[0] != 160) begin
      errors++;
      $display("FAIL frame_start got n=%0d t0=%0d t1=%0d exp n=2 t0=%0d t1=%0d",
               fs_n, fs_t[0], fs_t[1], LAT, LAT + 160);
    end
    vectors++;
    if (vs_low != 64) begin
      errors++;
      $display("FAIL vs_width got %0d exp 64", vs_low);
    end
    vectors++;
    if (vf_h != LAT || vf_v != 7) begin
      errors++;
      $display("FAIL vs_fall got %0d,%0d exp %0d,7", vf_h, vf_v, LAT);
    end
    vectors++;
    if (vb_h != LAT || vb_v != 6) begin
      errors++;
      $display("FAIL vblank_start got %0d,%0d exp %0d,6", vb_h, vb_v, LAT);
    end
    vectors++;
    if (s_fc !== 8'd2) begin
      errors++;
      $display("FAIL frame_count got %0d exp 2", s_fc);
    end
  endtask

  task automatic test_reset_mid_frame();
    tick(1'b1, 1'b1);
    for (int i = 0; i < 160 + 76; i++) tick(1'b0, 1'b1);
    vectors++;
    if ({s_h, s_v, s_fc} !== {10'd12, 10'd4, 8'd1}) begin
      errors++;
      $display("FAIL mid_pos got %0d,%0d,%0d exp 12,4,1", s_h, s_v, s_fc);
    end
    tick(1'b1, 1'b0);
    vectors++;
    if ({s_h, s_v, s_hs, s_vs, s_bn, s_sn, s_fs, s_vbs, s_fc} !==
        {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL mid_reset_small got %h", s_got());
    end
    vectors++;
    if (b_got() !== b_exp()) begin
      errors++;
      $display("FAIL mid_reset_big got %h exp %h", b_got(), b_exp());
    end
    tick(1'b0, 1'b1);
    vectors++;
    if ({s_h, s_v, s_fc} !== {10'd1, 10'd0, 8'd0}) begin
      errors++;
      $display("FAIL mid_restart got %0d,%0d,%0d exp 1,0,0", s_h, s_v, s_fc);
    end
  endtask

  task automatic test_frame_wrap();
    int   en_n;
    logic en;
    en_n = 0;
    tick(1'b1, 1'b1);
    for (int i = 0; en_n < 256 * 160 && i < 60000; i++) begin
      en = ($urandom_range(0, 7) != 0);
      tick(1'b0, en);
      if (en) en_n++;
      vectors++;
      if (s_got() !== s_exp()) begin
        errors++;
        $display("FAIL wrap_sb_small cyc %0d got %h exp %h",
                 i, s_got(), s_exp());
      end
      vectors++;
      if (b_got() !== b_exp()) begin
        errors++;
        $display("FAIL wrap_sb_big cyc %0d got %h exp %h",
                 i, b_got(), b_exp());
      end
      if (en && en_n == 255 * 160) begin
        vectors++;
        if (s_fc !== 8'd255) begin
          errors++;
          $display("FAIL count_255 got %0d exp 255", s_fc);
        end
      end
    end
    vectors++;
    if (s_fc !== 8'd0 || en_n != 256 * 160) begin
      errors++;
      $display("FAIL count_wrap got %0d after %0d en exp 0 after %0d",
               s_fc, en_n, 256 * 160);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_enable_hold();
    test_frame();
    test_reset_mid_frame();
    test_frame_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
